// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared types and constants for the intersection controller
package traffic_pkg;

  typedef enum logic [1:0] {
    ALLRED = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2
  } tl_state_e;

  localparam logic DIR0 = 1'b0;
  localparam logic DIR1 = 1'b1;

  localparam logic [1:0] ALL_RED = 2'b11;

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - saturating phase counter with synchronous clear
module phase_timer #(
  parameter int CNT_W = 4,
  parameter int SAT   = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] SAT_V = CNT_W'(SAT);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (r_count != SAT_V) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/traffic_scheduler.sv
// rtl/traffic_scheduler.sv - actuated two-direction intersection lamp sequencer
module traffic_scheduler
  import traffic_pkg::*;
#(
  parameter int GREEN_MIN = 6,
  parameter int GREEN_MAX = 12,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 4,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] car_req,
  input  logic [1:0] ped_req,
  output logic [1:0] r,
  output logic [1:0] y,
  output logic [1:0] g,
  output logic [1:0] walk,
  output logic       green_start
);

  localparam logic [CNT_W-1:0] ALLRED_END = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] YELLOW_END = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] GMIN_END   = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_END   = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] WALK_LEN   = CNT_W'(WALK_T);

  tl_state_e        r_state;
  logic             r_dir;
  logic [1:0]       r_ped_pend;
  logic             r_walk_act;

  logic [CNT_W-1:0] w_timer;
  logic             w_o;
  logic             w_cross;
  logic             w_advance;
  logic [1:0]       w_pend_next;

  assign w_o     = ~r_dir;
  assign w_cross = car_req[w_o] | r_ped_pend[w_o];

  always_comb begin
    w_advance = 1'b0;
    case (r_state)
      ALLRED:  w_advance = (w_timer == ALLRED_END);
      // own demand only stretches green until the max timer is reached
      GREEN:   w_advance = w_cross && (w_timer >= GMIN_END) &&
                           (!car_req[r_dir] || (w_timer == GMAX_END));
      YELLOW:  w_advance = (w_timer == YELLOW_END);
      default: w_advance = 1'b0;
    endcase
  end

  // a button press coinciding with green entry is served, so the clear wins
  always_comb begin
    w_pend_next = r_ped_pend | ped_req;
    if (r_state == ALLRED && w_advance) begin
      w_pend_next[w_o] = 1'b0;
    end
  end

  phase_timer #(
    .CNT_W(CNT_W),
    .SAT  (GREEN_MAX - 1)
  ) u_phase_timer (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_advance),
    .o_count(w_timer)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ALLRED;
      r_dir      <= DIR1;
      r_ped_pend <= 2'b00;
      r_walk_act <= 1'b0;
    end else begin
      r_ped_pend <= w_pend_next;
      if (w_advance) begin
        case (r_state)
          ALLRED: begin
            r_state    <= GREEN;
            r_dir      <= w_o;
            r_walk_act <= r_ped_pend[w_o] | ped_req[w_o];
          end
          GREEN:   r_state <= YELLOW;
          YELLOW:  r_state <= ALLRED;
          default: r_state <= ALLRED;
        endcase
      end
    end
  end

  always_comb begin
    r           = ALL_RED;
    y           = 2'b00;
    g           = 2'b00;
    walk        = 2'b00;
    green_start = 1'b0;
    case (r_state)
      GREEN: begin
        r           = 2'b00;
        r[w_o]      = 1'b1;
        g[r_dir]    = 1'b1;
        walk[r_dir] = r_walk_act && (w_timer < WALK_LEN);
        green_start = (w_timer == '0);
      end
      YELLOW: begin
        r        = 2'b00;
        r[w_o]   = 1'b1;
        y[r_dir] = 1'b1;
      end
      default: r = ALL_RED;
    endcase
  end

endmodule

// File: tb/tb_traffic_scheduler.sv
// tb/tb_traffic_scheduler.sv - self-checking bench for traffic_scheduler
module tb_traffic_scheduler;

  localparam int GREEN_MIN = 6;
  localparam int GREEN_MAX = 12;
  localparam int YELLOW_T  = 2;
  localparam int ALLRED_T  = 1;
  localparam int WALK_T    = 4;
  localparam int CNT_W     = 4;

  logic       clk;
  logic       rst;
  logic [1:0] car_req;
  logic [1:0] ped_req;
  logic [1:0] r, y, g, walk;
  logic       green_start;

  int total = 0;
  int bad   = 0;

  // reference model: phase 0=all-red 1=green 2=yellow, el = cycles spent in phase
  int     m_phase;
  int     m_dir;
  int     m_el;
  bit [1:0] m_pend;
  bit     m_wact;

  traffic_scheduler #(
    .GREEN_MIN(GREEN_MIN), .GREEN_MAX(GREEN_MAX), .YELLOW_T(YELLOW_T),
    .ALLRED_T(ALLRED_T), .WALK_T(WALK_T), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .car_req(car_req), .ped_req(ped_req),
    .r(r), .y(y), .g(g), .walk(walk), .green_start(green_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [8:0] model_out();
    logic [1:0] rr, yy, gg, ww;
    logic gs;
    rr = 2'b11; yy = 2'b00; gg = 2'b00; ww = 2'b00; gs = 1'b0;
    if (m_phase == 1) begin
      rr = 2'b00; rr[1 - m_dir] = 1'b1; gg[m_dir] = 1'b1;
      gs = (m_el == 0);
      if (m_el < WALK_T && m_wact) ww[m_dir] = 1'b1;
    end else if (m_phase == 2) begin
      rr = 2'b00; rr[1 - m_dir] = 1'b1; yy[m_dir] = 1'b1;
    end
    return {rr, yy, gg, ww, gs};
  endfunction

  // apply inputs for the coming edge, advance the model, sample at the falling edge
  task automatic tick(input logic [1:0] car, input logic [1:0] ped, input logic rn);
    bit [1:0] pn;
    int o;
    car_req = car;
    ped_req = ped;
    rst     = rn;
    if (!rn) begin
      m_phase = 0; m_dir = 1; m_el = 0; m_pend = 2'b00; m_wact = 1'b0;
    end else begin
      o  = 1 - m_dir;
      pn = m_pend | ped;
      case (m_phase)
        0: if (m_el + 1 >= ALLRED_T) begin
             m_phase = 1; m_dir = o; m_wact = pn[o]; pn[o] = 1'b0; m_el = 0;
           end else m_el++;
        1: if ((car[o] || m_pend[o]) && m_el >= GREEN_MIN - 1 &&
               (!car[m_dir] || m_el >= GREEN_MAX - 1)) begin
             m_phase = 2; m_el = 0;
           end else m_el++;
        default: if (m_el + 1 >= YELLOW_T) begin
             m_phase = 0; m_el = 0;
           end else m_el++;
      endcase
      m_pend = pn;
    end
    @(negedge clk);
  endtask

  task automatic restart(input logic [1:0] car, input logic [1:0] ped);
    tick(2'b00, 2'b00, 1'b0);
    tick(2'b00, 2'b00, 1'b0);
    tick(car, ped, 1'b1);
  endtask

  task automatic test_reset();
    tick(2'b11, 2'b11, 1'b0);
    tick(2'b11, 2'b11, 1'b0);
    total++;
    if ({r, y, g, walk, green_start} !== {2'b11, 2'b00, 2'b00, 2'b00, 1'b0}) begin
      bad++;
      $display("FAIL reset_outputs: got r=%b y=%b g=%b walk=%b gs=%b want r=11 y=00 g=00 walk=00 gs=0",
               r, y, g, walk, green_start);
    end
  endtask

  task automatic test_rest();
    int gs_cnt, off_cnt;
    tick(2'b00, 2'b00, 1'b0);
    tick(2'b00, 2'b00, 1'b1);
    total++;
    if ({g, r, green_start} !== {2'b01, 2'b10, 1'b1}) begin
      bad++;
      $display("FAIL first_green: got g=%b r=%b gs=%b want g=01 r=10 gs=1", g, r, green_start);
    end
    gs_cnt = 0; off_cnt = 0;
    repeat (55) begin
      tick(2'b00, 2'b00, 1'b1);
      if (green_start) gs_cnt++;
      if (g !== 2'b01) off_cnt++;
    end
    total++;
    if (gs_cnt != 0 || off_cnt != 0) begin
      bad++;
      $display("FAIL green_rest: got extra_gs=%0d non_green=%0d want 0 and 0", gs_cnt, off_cnt);
    end
  endtask

  task automatic test_car_handoff();
    int ng, ny, na;
    restart(2'b10, 2'b00);
    ng = 0; ny = 0; na = 0;
    while (g == 2'b01 && ng < 100) begin ng++; tick(2'b10, 2'b00, 1'b1); end
    while (y == 2'b01 && ny < 100) begin ny++; tick(2'b10, 2'b00, 1'b1); end
    while (r == 2'b11 && na < 100) begin na++; tick(2'b10, 2'b00, 1'b1); end
    total++;
    if (ng != GREEN_MIN || ny != YELLOW_T || na != ALLRED_T) begin
      bad++;
      $display("FAIL handoff_lengths: got green=%0d yellow=%0d allred=%0d want %0d %0d %0d",
               ng, ny, na, GREEN_MIN, YELLOW_T, ALLRED_T);
    end
    total++;
    if ({g, green_start} !== {2'b10, 1'b1}) begin
      bad++;
      $display("FAIL handoff_green1: got g=%b gs=%b want g=10 gs=1", g, green_start);
    end
  endtask

  task automatic test_both();
    int n, gap;
    logic [1:0] want_g;
    restart(2'b11, 2'b00);
    want_g = 2'b01;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (g !== want_g) begin
        bad++;
        $display("FAIL both_dir%0d: got g=%b want g=%b", k, g, want_g);
      end
      n = 0;
      while (g != 2'b00 && n < 100) begin n++; tick(2'b11, 2'b00, 1'b1); end
      total++;
      if (n != GREEN_MAX) begin
        bad++;
        $display("FAIL both_len%0d: got %0d cycles want %0d", k, n, GREEN_MAX);
      end
      gap = 0;
      while (g == 2'b00 && gap < 100) begin gap++; tick(2'b11, 2'b00, 1'b1); end
      want_g = ~want_g;
    end
  endtask

  task automatic test_ped();
    int n, gap, wcnt, off_cnt;
    restart(2'b00, 2'b00);
    n = 0;
    while (g == 2'b01 && n < 100) begin
      n++;
      tick(2'b00, (n == 3) ? 2'b10 : 2'b00, 1'b1);
    end
    total++;
    if (n != GREEN_MIN) begin
      bad++;
      $display("FAIL ped_green0_len: got %0d want %0d", n, GREEN_MIN);
    end
    gap = 0;
    while (g == 2'b00 && gap < 20) begin gap++; tick(2'b00, 2'b00, 1'b1); end
    wcnt = 0; off_cnt = 0;
    repeat (20) begin
      if (walk == 2'b10) wcnt++;
      if (g !== 2'b10) off_cnt++;
      tick(2'b00, 2'b00, 1'b1);
    end
    total++;
    if (wcnt != WALK_T || off_cnt != 0) begin
      bad++;
      $display("FAIL ped_walk1: got walk_cycles=%0d non_green1=%0d want %0d and 0", wcnt, off_cnt, WALK_T);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    restart(2'b00, 2'b00);
    tick(2'b10, 2'b01, 1'b1);
    n = 0;
    while (y != 2'b01 && n < 100) begin n++; tick(2'b10, 2'b00, 1'b1); end
    tick(2'b10, 2'b00, 1'b0);
    total++;
    if ({r, y, g, walk, green_start} !== {2'b11, 2'b00, 2'b00, 2'b00, 1'b0}) begin
      bad++;
      $display("FAIL midreset_out: got r=%b y=%b g=%b walk=%b gs=%b want r=11 others 0",
               r, y, g, walk, green_start);
    end
    tick(2'b00, 2'b00, 1'b1);
    total++;
    if ({g, walk, green_start} !== {2'b01, 2'b00, 1'b1}) begin
      bad++;
      $display("FAIL midreset_restart: got g=%b walk=%b gs=%b want g=01 walk=00 gs=1", g, walk, green_start);
    end
  endtask

  task automatic test_walk_entry();
    int wcnt, n, off_cnt;
    restart(2'b00, 2'b01);
    wcnt = 0;
    repeat (10) begin
      if (walk == 2'b01) wcnt++;
      tick(2'b00, 2'b00, 1'b1);
    end
    total++;
    if (wcnt != WALK_T) begin
      bad++;
      $display("FAIL entry_walk0: got %0d walk cycles want %0d", wcnt, WALK_T);
    end
    n = 0;
    while (g != 2'b10 && n < 30) begin n++; tick(2'b10, 2'b00, 1'b1); end
    off_cnt = 0;
    repeat (30) begin
      tick(2'b00, 2'b00, 1'b1);
      if (g !== 2'b10) off_cnt++;
    end
    total++;
    if (off_cnt != 0 || n >= 30) begin
      bad++;
      $display("FAIL entry_pend0_clear: got non_green1=%0d reach=%0d want 0 and <30", off_cnt, n);
    end
  endtask

  task automatic test_random();
    logic [1:0] car, ped;
    logic rn;
    logic [8:0] exp_o;
    restart(2'b00, 2'b00);
    car = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) car = 2'($urandom_range(3));
      ped = ($urandom_range(11) == 0) ? 2'($urandom_range(3)) : 2'b00;
      rn  = ($urandom_range(299) != 0);
      tick(car, ped, rn);
      exp_o = model_out();
      total++;
      if ({r, y, g, walk, green_start} !== exp_o) begin
        bad++;
        $display("FAIL random_cycle%0d: got r=%b y=%b g=%b walk=%b gs=%b want %b", i,
                 r, y, g, walk, green_start, exp_o);
      end
      total++;
      if (((r ^ y ^ g) !== 2'b11) || (((r & y) | (r & g) | (y & g)) !== 2'b00)) begin
        bad++;
        $display("FAIL one_lamp%0d: got r=%b y=%b g=%b want one lamp per direction", i, r, y, g);
      end
    end
  endtask

  initial begin
    rst = 1'b0; car_req = 2'b00; ped_req = 2'b00;
    m_phase = 0; m_dir = 1; m_el = 0; m_pend = 2'b00; m_wact = 1'b0;
    test_reset();
    test_rest();
    test_car_handoff();
    test_both();
    test_ped();
    test_reset_mid();
    test_walk_entry();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
